logic_gate_pipe: RTL
====================

# logic_gate_pipe

Parametrised, pipelined successor to the structural two-input gate set. It applies one of eight bitwise gate functions, selected per transaction by an opcode, to WIDTH-bit operands. It adds a valid/ready handshake, two register stages with backpressure, an accumulate mode that feeds the previous result back as operand A, and registered zero/parity flags. It sits between an operand source and a result consumer in the datapath examples.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand transaction offered
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A (ignored when acc=1)
- b  input  WIDTH  operand B
- op  input  3  gate select (see Operation)
- acc  input  1  1 = use accumulator as operand A
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- zero  output  1  y == 0
- parity  output  1  XOR-reduction of y

## Operation
- Opcode map:
  - 0 = AND
  - 1 = OR
  - 2 = NOT A
  - 3 = NOT B
  - 4 = NAND
  - 5 = NOR
  - 6 = XOR
  - 7 = XNOR
- All operations are bitwise over WIDTH bits. NOT A and NOT B ignore the other operand.
- Stage 0 (capture):
  - On in_valid && in_ready, registers a, b, op and acc.
  - Sets s0_valid.
- Stage 1 (compute/output):
  - On the s0→s1 transfer, computes f(op, A_eff, b).
  - A_eff = acc ? acc_reg : a.
  - Registers the result into y.
  - zero and parity are computed from the same result and registered alongside y.
  - Sets out_valid.
- Accumulator acc_reg:
  - Loads the computed result on every s0→s1 transfer, whether or not acc was set.
  - Holds its value otherwise.
- Advance rules:
  - s1_advance = !out_valid || out_ready
  - s0 transfers when s0_valid && s1_advance
  - in_ready = !s0_valid || s1_advance (combinational)
- Output drain: out_valid clears when out_ready && out_valid and no new transfer enters s1 in that cycle.
- Stalls: while out_valid && !out_ready, y, zero and parity are held stable.
- Transactions are never dropped, duplicated or reordered.

## Timing
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+1 (2-register pipeline).
- Throughput: one transaction per cycle while out_ready=1.
- Back-to-back acc=1 transactions chain with no bubble. Each uses the result of the immediately preceding transaction, because acc_reg updates on the same edge that result enters s1.
- Full: both stages valid and out_ready=0 gives in_ready=0. Upstream must hold a, b, op and acc stable until accepted.
- Simultaneous drain and fill: if out_ready=1 and s0_valid=1 on the same edge, s1 reloads and out_valid stays 1.
- Reset values (applied on the rst edge, overriding all activity including mid-transaction):
  - s0_valid = 0, out_valid = 0
  - y = 0, zero = 0, parity = 0
  - acc_reg = 0
  - in_ready reads 1 in the first cycle after reset.
- In-flight transactions are discarded on reset.
- zero and parity are meaningful only while out_valid=1.

## Structure
- Shared package `logic_gate_pkg`:
  - Opcode localparams OP_AND … OP_XNOR (3-bit)
  - Pure function `gate_eval(op, a, b)` returning WIDTH bits
- One sub-module, `logic_gate_core`: purely combinational WIDTH-bit gate evaluator wrapping `gate_eval`. The pipeline wrapper holds all registers, the handshake and acc_reg.

## Test plan
All scenarios use WIDTH=8.
- Reset/idle: assert rst for 2 cycles with in_valid=1 → out_valid=0, y=0, in_ready=1 after release, and no result emitted for the input offered during reset.
- Opcode sweep:
  - Stimulus: a=0xC5, b=0xA3, op 0..7 back-to-back, out_ready=1.
  - Required y sequence: 0x81, 0xE7, 0x3A, 0x5C, 0x7E, 0x18, 0x66, 0x99.
  - Each result appears 2 cycles after acceptance, one per cycle.
- Accumulate chain:
  - Stimulus: op=OR a=0x01 b=0x00 acc=0, then op=XOR b=0xFF acc=1, then op=AND b=0x0F acc=1.
  - Required y: 0x01, 0xFE, 0x0E, with no bubbles.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles while 3 transactions are offered.
  - Required: in_ready drops after 2 acceptances, y is held stable, the third transaction is accepted once out_ready=1, and all 3 results arrive in order.
- Flags:
  - op=XOR a=b=0x5A → y=0x00, zero=1, parity=0.
  - op=NOT A a=0xFE → y=0x01, zero=0, parity=1.
- Mid-operation reset:
  - Stimulus: assert rst with both stages full and acc_reg=0x3C.
  - Required: outputs return to reset values. A following acc=1 op=OR b=0x00 yields y=0x00, proving acc_reg was cleared.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the pipelined gate block: opcodes, stage control word
// and the bitwise gate evaluator used by the combinational core.
package logic_gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOTA = 3'd2;
  localparam logic [2:0] OP_NOTB = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  // Widest operand the evaluator handles; instances trim to their own WIDTH.
  localparam int GATE_MAX_W = 64;

  typedef logic [GATE_MAX_W-1:0] gate_word_t;

  // Per-transaction control captured in stage 0 alongside the operands.
  typedef struct packed {
    logic [2:0] op;
    logic       acc;
  } ctl_t;

  // Bitwise gate select; NOT A / NOT B ignore the other operand.
  function automatic gate_word_t gate_eval(input logic [2:0] op,
                                           input gate_word_t a,
                                           input gate_word_t b);
    gate_word_t r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOTA: r = ~a;
      OP_NOTB: r = ~b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_gate_core.sv
// Purpose: combinational WIDTH-bit gate evaluator (WIDTH up to GATE_MAX_W).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the enclosing pipeline owns all flow control.
module logic_gate_core
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  gate_word_t a_ext;
  gate_word_t b_ext;
  gate_word_t y_ext;
  gate_word_t y_hi_unused;

  // Zero-extend into the evaluator's word; bits above WIDTH are don't-care.
  assign a_ext       = gate_word_t'(a);
  assign b_ext       = gate_word_t'(b);
  assign y_ext       = gate_eval(op, a_ext, b_ext);
  assign y           = y_ext[WIDTH-1:0];
  assign y_hi_unused = y_ext >> WIDTH;

endmodule

// File: rtl/logic_gate_pipe.sv
// Purpose: two-stage valid/ready gate pipeline with accumulate mode and zero/parity flags.
// Latency: accepted at edge N, result valid after edge N+1; one result per cycle at full rate.
// Backpressure: out_ready low holds stage 1 stable; in_ready drops only when both stages are full.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  logic             s0_valid;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  ctl_t             s0_ctl;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] res;
  logic             s1_advance;
  logic             s0_xfer;
  logic             in_fire;

  assign s1_advance = !out_valid || out_ready;
  assign s0_xfer    = s0_valid && s1_advance;
  assign in_ready   = !s0_valid || s1_advance;
  assign in_fire    = in_valid && in_ready;

  // acc_reg always holds the previous transaction's result by the time the
  // next one computes, so back-to-back accumulate chains need no bubble.
  assign a_eff = s0_ctl.acc ? acc_reg : s0_a;

  logic_gate_core #(.WIDTH(WIDTH)) u_core (
    .op (s0_ctl.op),
    .a  (a_eff),
    .b  (s0_b),
    .y  (res)
  );

  // Stage 0: capture operands on acceptance, empty when passed on to stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_ctl   <= '0;
    end else if (in_fire) begin
      s0_valid <= 1'b1;
      s0_a     <= a;
      s0_b     <= b;
      s0_ctl   <= '{op: op, acc: acc};
    end else if (s0_xfer) begin
      s0_valid <= 1'b0;
    end
  end

  // Stage 1: register result, flags and accumulator; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b0;
      parity    <= 1'b0;
      acc_reg   <= '0;
    end else if (s0_xfer) begin
      out_valid <= 1'b1;
      y         <= res;
      zero      <= (res == '0);
      parity    <= ^res;
      acc_reg   <= res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
